alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter OP_LEN, default 5, width of op; the data width is fixed at 32 bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port op  input  OP_LEN  operation select.
REQ-005 SHALL have port in1  input  32  operand A (shift amount source for variable shifts).
REQ-006 SHALL have port in2  input  32  operand B (value being shifted for all shifts).
REQ-007 SHALL have port shift_imm  input  5  immediate shift amount for SLL/SRL/SRA.
REQ-008 SHALL have port ext_mode  input  1  0 = signed compare/arith, 1 = unsigned variants.
REQ-009 SHALL have port out  output  32  registered result.
REQ-010 SHALL have port zero  output  1  registered flag, high when the result is 0.
REQ-011 SHALL have port neg  output  1  registered flag, equal to result bit 31.

Function
REQ-012 SHALL use op encodings: NONE=0, ADD=1, SUB=2, MUL=3, DIV=4, MOD=5, SLT=6, AND=7, OR=8, XOR=9, NOR=10, SLL=11, SLLV=12, SRL=13, SRLV=14, SRA=15, SRAV=16.
REQ-013 SHALL compute the result combinationally from the current inputs and register out/zero/neg on each rising clk edge; latency exactly 1 cycle, a new operation accepted every cycle.
REQ-014 SHALL output 0 for NONE and for any unused encoding (17..2^OP_LEN-1).
REQ-015 ADD/SUB: in1+in2 / in1-in2, wrapping modulo 2^32, no overflow flag; 0x7FFFFFFF+1 = 0x80000000.
REQ-016 MUL: low 32 bits of the product; identical for signed and unsigned operands.
REQ-017 DIV/MOD: ext_mode=0 signed, quotient truncated toward zero, remainder sign follows in1; ext_mode=1 unsigned.
REQ-018 Divide by zero: DIV returns 0xFFFFFFFF, MOD returns in1, for either ext_mode value.
REQ-019 Signed overflow 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000, MOD returns 0.
REQ-020 SLT: 1 when in1 < in2 (signed if ext_mode=0, unsigned if ext_mode=1), else 0.
REQ-021 AND/OR/XOR/NOR: bitwise on in1, in2; NOR = ~(in1|in2).
REQ-022 SLL/SRL/SRA: shift in2 by shift_imm; SLLV/SRLV/SRAV: shift in2 by in1[4:0], upper bits of in1 ignored.
REQ-023 SRL/SRLV zero-fill; SRA/SRAV replicate in2[31]; a shift amount of 0 returns in2 unchanged.
REQ-024 ext_mode SHALL affect only SLT, DIV and MOD.
REQ-025 zero and neg SHALL be derived from the same 32-bit result that is registered into out, in the same cycle.

Reset
REQ-026 While rst_n=0, out=0, zero=1 and neg=0, applied immediately without waiting for a clock edge.
REQ-027 On rst_n deassertion, the first rising edge SHALL register the result of the inputs present at that edge; an operation interrupted by reset is discarded.

Verification
REQ-028 ADD 1+2 -> out=3, zero=0, neg=0 one cycle later; ADD 0x7FFFFFFF+1 -> 0x80000000, neg=1; ADD 0x7FFFFFFF+0x80000000 -> 0xFFFFFFFF.
REQ-029 SUB 2-2 -> 0, zero=1; MUL 2*3 -> 6; DIV 7/3 -> 2; MOD 7%3 -> 1; DIV -7/2 (signed) -> 0xFFFFFFFD; DIV x/0 -> 0xFFFFFFFF.
REQ-030 SLT 1<2 -> 1; SLT 0xFFFFFFFF<1 -> 1 with ext_mode=0, 0 with ext_mode=1; AND/OR/XOR/NOR of 0x00FF00FF, 0x0000FFFF -> 0x000000FF / 0x00FFFFFF / 0x00FFFF00 / 0xFF000000.
REQ-031 SLL 0x000FF000 by imm 4 -> 0x00FF0000; SLLV with in1=8 -> 0x0FF00000; SRL imm 4 -> 0x0000FF00; SRLV in1=8 -> 0x00000FF0.
REQ-032 SRA -8 by imm 1 -> 0xFFFFFFFC; SRAV in1=2 on -8 -> 0xFFFFFFFE; SRAV in1=0x22 uses amount 2 -> 0xFFFFFFFE.
REQ-033 Assert rst_n=0 mid-stream between clock edges -> out=0, zero=1, neg=0 immediately; after release, NONE -> out=0, zero=1.

Source files
------------

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 32-bit registered arithmetic/logic unit
//
// Computes one operation per cycle from the current inputs and registers the
// result together with zero/negative flags on the next rising clock edge.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset (out=0, zero=1, neg=0)
//   op         operation select (OP_LEN bits, see OP_* encodings below)
//   in1        operand A; shift amount source for SLLV/SRLV/SRAV
//   in2        operand B; the value being shifted for every shift op
//   shift_imm  immediate shift amount for SLL/SRL/SRA
//   ext_mode   0 = signed SLT/DIV/MOD, 1 = unsigned variants
//   out        registered 32-bit result
//   zero       registered flag, high when the result is 0
//   neg        registered flag, copy of result bit 31
// ---------------------------------------------------------------------------
module alu #(
  parameter int OP_LEN = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_LEN-1:0] op,
  input  logic [31:0]       in1,
  input  logic [31:0]       in2,
  input  logic [4:0]        shift_imm,
  input  logic              ext_mode,
  output logic [31:0]       out,
  output logic              zero,
  output logic              neg
);

  localparam logic [OP_LEN-1:0] OP_NONE = OP_LEN'(0);
  localparam logic [OP_LEN-1:0] OP_ADD  = OP_LEN'(1);
  localparam logic [OP_LEN-1:0] OP_SUB  = OP_LEN'(2);
  localparam logic [OP_LEN-1:0] OP_MUL  = OP_LEN'(3);
  localparam logic [OP_LEN-1:0] OP_DIV  = OP_LEN'(4);
  localparam logic [OP_LEN-1:0] OP_MOD  = OP_LEN'(5);
  localparam logic [OP_LEN-1:0] OP_SLT  = OP_LEN'(6);
  localparam logic [OP_LEN-1:0] OP_AND  = OP_LEN'(7);
  localparam logic [OP_LEN-1:0] OP_OR   = OP_LEN'(8);
  localparam logic [OP_LEN-1:0] OP_XOR  = OP_LEN'(9);
  localparam logic [OP_LEN-1:0] OP_NOR  = OP_LEN'(10);
  localparam logic [OP_LEN-1:0] OP_SLL  = OP_LEN'(11);
  localparam logic [OP_LEN-1:0] OP_SLLV = OP_LEN'(12);
  localparam logic [OP_LEN-1:0] OP_SRL  = OP_LEN'(13);
  localparam logic [OP_LEN-1:0] OP_SRLV = OP_LEN'(14);
  localparam logic [OP_LEN-1:0] OP_SRA  = OP_LEN'(15);
  localparam logic [OP_LEN-1:0] OP_SRAV = OP_LEN'(16);

  logic [31:0] result;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;
  logic        div_overflow;
  logic        less_than;
  logic [4:0]  var_amt;

  assign div_by_zero  = (in2 == 32'd0);
  // Only the signed form can overflow: -2^31 / -1 has no 32-bit quotient.
  assign div_overflow = !ext_mode && (in1 == 32'h8000_0000) && (in2 == 32'hFFFF_FFFF);
  assign var_amt      = in1[4:0];

  // Divider/remainder with the divide-by-zero and overflow corner cases
  // pinned to fixed values so the signed operators never see them.
  always_comb begin
    quot = 32'd0;
    rem  = 32'd0;
    if (div_by_zero) begin
      quot = 32'hFFFF_FFFF;
      rem  = in1;
    end else if (div_overflow) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end else if (ext_mode) begin
      quot = in1 / in2;
      rem  = in1 % in2;
    end else begin
      quot = $unsigned($signed(in1) / $signed(in2));
      rem  = $unsigned($signed(in1) % $signed(in2));
    end
  end

  always_comb begin
    if (ext_mode) less_than = (in1 < in2);
    else          less_than = ($signed(in1) < $signed(in2));
  end

  // Result selection; NONE and every unused encoding produce 0.
  always_comb begin
    result = 32'd0;
    case (op)
      OP_NONE: result = 32'd0;
      OP_ADD:  result = in1 + in2;
      OP_SUB:  result = in1 - in2;
      OP_MUL:  result = in1 * in2;
      OP_DIV:  result = quot;
      OP_MOD:  result = rem;
      OP_SLT:  result = {31'd0, less_than};
      OP_AND:  result = in1 & in2;
      OP_OR:   result = in1 | in2;
      OP_XOR:  result = in1 ^ in2;
      OP_NOR:  result = ~(in1 | in2);
      OP_SLL:  result = in2 << shift_imm;
      OP_SLLV: result = in2 << var_amt;
      OP_SRL:  result = in2 >> shift_imm;
      OP_SRLV: result = in2 >> var_amt;
      OP_SRA:  result = $unsigned($signed(in2) >>> shift_imm);
      OP_SRAV: result = $unsigned($signed(in2) >>> var_amt);
      default: result = 32'd0;
    endcase
  end

  // Output register; flags come from the same result word as out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= 32'd0;
      zero <= 1'b1;
      neg  <= 1'b0;
    end else begin
      out  <= result;
      zero <= (result == 32'd0);
      neg  <= result[31];
    end
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [4:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [4:0]  shift_imm;
  logic        ext_mode;
  logic [31:0] out;
  logic        zero;
  logic        neg;

  int total = 0;
  int bad   = 0;

  alu #(.OP_LEN(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .shift_imm (shift_imm),
    .ext_mode  (ext_mode),
    .out       (out),
    .zero      (zero),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  imm;
    logic        ext;
    logic [31:0] exp;
  } vec_t;

  // Behavioural reference computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] imm,
                                          input logic ext);
    longint ua, ub, sa, sb, r, p2;
    int n;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = $signed(a);
    sb = $signed(b);
    r  = 0;
    n  = (o == 5'd12 || o == 5'd14 || o == 5'd16) ? int'(a % 32) : int'(imm);
    p2 = longint'(1) << n;
    case (o)
      5'd1:  r = ua + ub;
      5'd2:  r = ua - ub;
      5'd3:  r = ua * ub;
      5'd4:  r = (b == 0) ? -1 : (ext ? ua / ub : sa / sb);
      5'd5:  r = (b == 0) ? ua : (ext ? ua % ub : sa % sb);
      5'd6:  r = ext ? longint'(ua < ub) : longint'(sa < sb);
      5'd7:  r = ua & ub;
      5'd8:  r = ua | ub;
      5'd9:  r = ua ^ ub;
      5'd10: r = ~(ua | ub);
      5'd11, 5'd12: r = ub * p2;
      5'd13, 5'd14: r = ub / p2;
      5'd15, 5'd16: r = (sb >= 0) ? sb / p2 : -((-sb + p2 - 1) / p2);
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic drive(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] imm, input logic ext);
    op = o; in1 = a; in2 = b; shift_imm = imm; ext_mode = ext;
  endtask

  task automatic test_reset;
    drive(5'd1, 32'd1, 32'd2, 5'd0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out !== 32'd0 || zero !== 1'b1 || neg !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state: got out=%h zero=%b neg=%b want out=0 zero=1 neg=0", out, zero, neg);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    vec_t v[$];
    v.push_back('{5'd1,  32'd1,          32'd2,          5'd0, 1'b0, 32'd3});
    v.push_back('{5'd1,  32'h7FFFFFFF,   32'd1,          5'd0, 1'b0, 32'h80000000});
    v.push_back('{5'd1,  32'h7FFFFFFF,   32'h80000000,   5'd0, 1'b1, 32'hFFFFFFFF});
    v.push_back('{5'd2,  32'd2,          32'd2,          5'd0, 1'b0, 32'd0});
    v.push_back('{5'd3,  32'd2,          32'd3,          5'd0, 1'b0, 32'd6});
    v.push_back('{5'd4,  32'd7,          32'd3,          5'd0, 1'b0, 32'd2});
    v.push_back('{5'd5,  32'd7,          32'd3,          5'd0, 1'b0, 32'd1});
    v.push_back('{5'd4,  32'hFFFFFFF9,   32'd2,          5'd0, 1'b0, 32'hFFFFFFFD});
    v.push_back('{5'd5,  32'hFFFFFFF9,   32'd2,          5'd0, 1'b0, 32'hFFFFFFFF});
    v.push_back('{5'd4,  32'hFFFFFFF9,   32'd2,          5'd0, 1'b1, 32'h7FFFFFFC});
    v.push_back('{5'd4,  32'd5,          32'd0,          5'd0, 1'b0, 32'hFFFFFFFF});
    v.push_back('{5'd4,  32'd5,          32'd0,          5'd0, 1'b1, 32'hFFFFFFFF});
    v.push_back('{5'd5,  32'd5,          32'd0,          5'd0, 1'b1, 32'd5});
    v.push_back('{5'd4,  32'h80000000,   32'hFFFFFFFF,   5'd0, 1'b0, 32'h80000000});
    v.push_back('{5'd5,  32'h80000000,   32'hFFFFFFFF,   5'd0, 1'b0, 32'd0});
    v.push_back('{5'd6,  32'd1,          32'd2,          5'd0, 1'b0, 32'd1});
    v.push_back('{5'd6,  32'hFFFFFFFF,   32'd1,          5'd0, 1'b0, 32'd1});
    v.push_back('{5'd6,  32'hFFFFFFFF,   32'd1,          5'd0, 1'b1, 32'd0});
    v.push_back('{5'd7,  32'h00FF00FF,   32'h0000FFFF,   5'd0, 1'b0, 32'h000000FF});
    v.push_back('{5'd8,  32'h00FF00FF,   32'h0000FFFF,   5'd0, 1'b0, 32'h00FFFFFF});
    v.push_back('{5'd9,  32'h00FF00FF,   32'h0000FFFF,   5'd0, 1'b0, 32'h00FFFF00});
    v.push_back('{5'd10, 32'h00FF00FF,   32'h0000FFFF,   5'd0, 1'b0, 32'hFF000000});
    v.push_back('{5'd11, 32'd0,          32'h000FF000,   5'd4, 1'b0, 32'h00FF0000});
    v.push_back('{5'd12, 32'd8,          32'h000FF000,   5'd0, 1'b0, 32'h0FF00000});
    v.push_back('{5'd13, 32'd0,          32'h000FF000,   5'd4, 1'b0, 32'h0000FF00});
    v.push_back('{5'd14, 32'd8,          32'h000FF000,   5'd0, 1'b0, 32'h00000FF0});
    v.push_back('{5'd15, 32'd0,          32'hFFFFFFF8,   5'd1, 1'b0, 32'hFFFFFFFC});
    v.push_back('{5'd15, 32'd0,          32'hFFFFFFF8,   5'd0, 1'b0, 32'hFFFFFFF8});
    v.push_back('{5'd16, 32'd2,          32'hFFFFFFF8,   5'd0, 1'b0, 32'hFFFFFFFE});
    v.push_back('{5'd16, 32'h22,         32'hFFFFFFF8,   5'd0, 1'b0, 32'hFFFFFFFE});
    v.push_back('{5'd0,  32'd9,          32'd9,          5'd3, 1'b0, 32'd0});
    v.push_back('{5'd17, 32'd9,          32'd9,          5'd3, 1'b0, 32'd0});
    v.push_back('{5'd31, 32'hFFFFFFFF,   32'd9,          5'd3, 1'b1, 32'd0});
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].ext);
      @(posedge clk);
      #1;
      total++;
      if (out !== v[i].exp || zero !== (v[i].exp == 32'd0) || neg !== v[i].exp[31]) begin
        bad++;
        $display("[TB] FAIL directed_%0d op=%0d: got out=%h zero=%b neg=%b want out=%h zero=%b neg=%b",
                 i, v[i].op, out, zero, neg, v[i].exp, (v[i].exp == 32'd0), v[i].exp[31]);
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Each cycle carries a new operation; the expectation for the op applied
  // before an edge is checked right after that edge.
  task automatic test_back_to_back;
    logic [31:0] a, b, e;
    logic [4:0]  o, imm;
    logic        x;
    for (int i = 0; i < 400; i++) begin
      o   = 5'($urandom_range(0, 31));
      a   = pick_operand();
      b   = pick_operand();
      imm = 5'($urandom);
      x   = 1'($urandom);
      e   = ref_alu(o, a, b, imm, x);
      drive(o, a, b, imm, x);
      @(posedge clk);
      #1;
      total++;
      if (out !== e || zero !== (e == 32'd0) || neg !== e[31]) begin
        bad++;
        $display("[TB] FAIL random_%0d op=%0d a=%h b=%h imm=%0d ext=%b: got out=%h z=%b n=%b want out=%h z=%b n=%b",
                 i, o, a, b, imm, x, out, zero, neg, e, (e == 32'd0), e[31]);
      end
    end
  endtask

  task automatic test_reset_midstream;
    drive(5'd1, 32'h80000000, 32'd5, 5'd0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 32'd0 || zero !== 1'b1 || neg !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midstream_reset: got out=%h zero=%b neg=%b want out=0 zero=1 neg=0", out, zero, neg);
    end
    drive(5'd1, 32'd5, 32'd5, 5'd0, 1'b0);
    @(posedge clk);
    #2;
    total++;
    if (out !== 32'd0 || zero !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_held: got out=%h zero=%b want out=0 zero=1", out, zero);
    end
    drive(5'd0, 32'd5, 32'd5, 5'd0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out !== 32'd0 || zero !== 1'b1 || neg !== 1'b0) begin
      bad++;
      $display("[TB] FAIL after_release_none: got out=%h zero=%b neg=%b want out=0 zero=1 neg=0", out, zero, neg);
    end
    drive(5'd1, 32'd4, 32'd4, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (out !== 32'd8 || zero !== 1'b0) begin
      bad++;
      $display("[TB] FAIL after_release_add: got out=%h zero=%b want out=00000008 zero=0", out, zero);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
